// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_addr_out;

   modport master (
      output start, funct3, rs1_data, rs2_data, rd_addr_in,
      input  busy, done, result, rd_addr_out
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, rd_addr_in,
      output busy, done, result, rd_addr_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide on magnitudes,
// with sign correction and divide special cases resolved when the result is registered.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [5:0] LAST_CNT = 6'(XLEN - 1);

   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
      return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t            state_r, state_s;
   logic [5:0]        cnt_r;
   logic [2*XLEN-1:0] acc_r, acc_s;
   logic [XLEN-1:0]   opb_r;
   logic [2:0]        op_r;
   logic              neg_a_r, neg_b_r;
   logic [4:0]        rd_cap_r;
   logic [XLEN-1:0]   result_r;
   logic [4:0]        rd_out_r;
   logic              busy_r, done_r;
   logic              busy_s, done_s;

   // Operand capture decode
   logic            signed_a_s, signed_b_s, a_neg_s, b_neg_s;
   logic [XLEN-1:0] a_mag_s, b_mag_s;
   logic            div_zero_s, div_ovf_s, special_s;
   logic [XLEN-1:0] special_res_s;

   always_comb begin
      signed_a_s = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      signed_b_s = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
      a_neg_s    = signed_a_s & bus.rs1_data[XLEN-1];
      b_neg_s    = signed_b_s & bus.rs2_data[XLEN-1];
      a_mag_s    = a_neg_s ? neg_w(bus.rs1_data) : bus.rs1_data;
      b_mag_s    = b_neg_s ? neg_w(bus.rs2_data) : bus.rs2_data;
      div_zero_s = bus.funct3[2] && (bus.rs2_data == {XLEN{1'b0}});
      div_ovf_s  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.rs2_data == {XLEN{1'b1}});
      special_s  = div_zero_s || div_ovf_s;
      if (bus.funct3[1]) begin
         special_res_s = div_zero_s ? bus.rs1_data : {XLEN{1'b0}};
      end else begin
         special_res_s = div_zero_s ? {XLEN{1'b1}} : bus.rs1_data;
      end
   end

   // One multiply or divide iteration; divide keeps the shifted-out bit so 2*rem+bit never overflows
   logic [XLEN:0]   sum_s;
   logic [XLEN:0]   part_s;
   logic [XLEN+1:0] diff_s;

   always_comb begin
      sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]};
      part_s = acc_r[2*XLEN-1:XLEN-1];
      diff_s = {1'b0, part_s} - {2'b00, opb_r};
      acc_s  = acc_r;
      if (op_r[2]) begin
         if (!diff_s[XLEN+1]) begin
            acc_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
         end else begin
            acc_s = {part_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
         end
      end else begin
         if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opb_r};
         end else begin
            sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
         end
         acc_s = {sum_s, acc_r[XLEN-1:1]};
      end
   end

   // Sign correction and word select applied to the final iteration's value
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, calc_res_s;

   always_comb begin
      prod_s = (neg_a_r ^ neg_b_r) ? neg_d(acc_s) : acc_s;
      quo_s  = (neg_a_r ^ neg_b_r) ? neg_w(acc_s[XLEN-1:0]) : acc_s[XLEN-1:0];
      rem_s  = neg_a_r ? neg_w(acc_s[2*XLEN-1:XLEN]) : acc_s[2*XLEN-1:XLEN];
      if (op_r[2]) begin
         calc_res_s = op_r[1] ? rem_s : quo_s;
      end else begin
         calc_res_s = (op_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s = special_s ? FINISH : CALC;
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == LAST_CNT) begin
               state_s = FINISH;
            end else begin
               state_s = CALC;
            end
         end
         FINISH:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_s)
         CALC:    busy_s = 1'b1;
         FINISH: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

   // Operand capture and iteration state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r    <= 6'd0;
         acc_r    <= {(2*XLEN){1'b0}};
         opb_r    <= {XLEN{1'b0}};
         op_r     <= 3'd0;
         neg_a_r  <= 1'b0;
         neg_b_r  <= 1'b0;
         rd_cap_r <= 5'd0;
      end else if ((state_r == IDLE) && bus.start) begin
         cnt_r    <= 6'd0;
         op_r     <= bus.funct3;
         neg_a_r  <= a_neg_s;
         neg_b_r  <= b_neg_s;
         rd_cap_r <= bus.rd_addr_in;
         if (bus.funct3[2]) begin
            acc_r <= {{XLEN{1'b0}}, a_mag_s};
            opb_r <= b_mag_s;
         end else begin
            acc_r <= {{XLEN{1'b0}}, b_mag_s};
            opb_r <= a_mag_s;
         end
      end else if (state_r == CALC) begin
         cnt_r <= cnt_r + 6'd1;
         acc_r <= acc_s;
      end else begin
         cnt_r <= cnt_r;
         acc_r <= acc_r;
      end
   end

   // Registered outputs; result and destination update only on FINISH entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= {XLEN{1'b0}};
         rd_out_r <= 5'd0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
         if ((state_r == IDLE) && (state_s == FINISH)) begin
            result_r <= special_res_s;
            rd_out_r <= bus.rd_addr_in;
         end else if ((state_r == CALC) && (state_s == FINISH)) begin
            result_r <= calc_res_s;
            rd_out_r <= rd_cap_r;
         end else begin
            result_r <= result_r;
            rd_out_r <= rd_out_r;
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.result      = result_r;
   assign bus.rd_addr_out = rd_out_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, done latency, start dropping and reset abort.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input int idx, input vec_t v, input logic [4:0] rd);
      int found;
      found = -1;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = v.f;
      bus.rs1_data   = v.a;
      bus.rs2_data   = v.b;
      bus.rd_addr_in = rd;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.rs1_data = 32'hDEAD_BEEF;
      bus.rs2_data = 32'h0BAD_F00D;
      check_eq($sformatf("v%0d_busy", idx), {31'd0, bus.busy}, 32'd1);
      for (int k = 0; k <= 40; k++) begin
         if (bus.done) begin
            found = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      check_eq($sformatf("v%0d_latency", idx), found, v.lat);
      check_eq($sformatf("v%0d_result", idx), bus.result, v.exp);
      check_eq($sformatf("v%0d_rd", idx), {27'd0, bus.rd_addr_out}, {27'd0, rd});
      @(posedge clk);
      #1;
      check_eq($sformatf("v%0d_done_drop", idx), {31'd0, bus.done}, 32'd0);
      check_eq($sformatf("v%0d_result_hold", idx), bus.result, v.exp);
   endtask

   initial begin
      int done_cnt;
      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
      vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        32};
      vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         32};
      vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0};
      vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         0};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
      vecs[12] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 0};
      vecs[13] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0};
      vecs[14] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32};
      vecs[15] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32};
      vecs[16] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32};
      vecs[17] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32};
      vecs[18] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32};
      vecs[19] = '{3'b000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 32};

      bus.start      = 1'b0;
      bus.funct3     = 3'b000;
      bus.rs1_data   = 32'd0;
      bus.rs2_data   = 32'd0;
      bus.rd_addr_in = 5'd0;
      #12;
      check_eq("rst_busy",   {31'd0, bus.busy}, 32'd0);
      check_eq("rst_done",   {31'd0, bus.done}, 32'd0);
      check_eq("rst_result", bus.result, 32'd0);
      check_eq("rst_rd",     {27'd0, bus.rd_addr_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         run_op(i, vecs[i], 5'(i + 1));
      end

      // start held every cycle during a MUL with a changing destination
      done_cnt = 0;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = 3'b000;
      bus.rs1_data   = 32'd6;
      bus.rs2_data   = 32'd9;
      bus.rd_addr_in = 5'd3;
      @(posedge clk);
      for (int k = 0; k <= 45; k++) begin
         #1;
         if (bus.done) begin
            done_cnt++;
            check_eq("spam_rd", {27'd0, bus.rd_addr_out}, 32'd3);
            check_eq("spam_result", bus.result, 32'd54);
            check_eq("spam_done_k", k, 32'd32);
         end
         bus.start      = (k <= 32);
         bus.rd_addr_in = 5'(k + 4);
         bus.rs1_data   = 32'(k);
         @(posedge clk);
      end
      bus.start = 1'b0;
      #1;
      check_eq("spam_done_count", done_cnt, 32'd1);
      check_eq("spam_idle", {31'd0, bus.busy}, 32'd0);

      // reset asserted at E10 of a DIV
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = 3'b100;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int k = 1; k < 10; k++) begin
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_eq("rstmid_busy",   {31'd0, bus.busy}, 32'd0);
      check_eq("rstmid_result", bus.result, 32'd0);
      check_eq("rstmid_rd",     {27'd0, bus.rd_addr_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            done_cnt++;
         end
      end
      check_eq("rstmid_no_done", done_cnt, 32'd0);
      run_op(20, vecs[6], 5'd31);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
